// File: rtl/regfile_wb_arbiter.sv
// Write-port controller for a 32-entry register file: zero-fills every register
// after reset, then round-robin arbitrates ALU and LSU writebacks onto one port.
module regfile_wb_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREG  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [WIDTH-1:0] alu_data,
  output logic             alu_ready,
  input  logic             lsu_valid,
  input  logic [4:0]       lsu_rd,
  input  logic [WIDTH-1:0] lsu_data,
  output logic             lsu_ready,
  output logic             rf_we,
  output logic [4:0]       rf_rd,
  output logic [WIDTH-1:0] rf_data,
  output logic             init_busy
);

  // Handshake: a source transfers on any rising edge where its valid and ready
  // are both high. Ready is combinational from both valids and last_grant, and
  // is only ever high for the one granted source; sources hold valid/rd/data
  // stable until their transfer.

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  localparam logic [4:0] LAST_IDX = 5'(NREG - 1);

  state_e           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  src_e             last_q, last_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_rd_q, rf_rd_d;
  logic [WIDTH-1:0] rf_data_q, rf_data_d;

  logic             grant_alu;
  logic             grant_lsu;

  // Round-robin grant; on contention the source that did not win last time goes.
  always_comb begin
    grant_alu = 1'b0;
    grant_lsu = 1'b0;
    if (state_q == ST_RUN) begin
      if (alu_valid && lsu_valid) begin
        if (last_q == SRC_LSU) begin
          grant_alu = 1'b1;
        end else begin
          grant_lsu = 1'b1;
        end
      end else begin
        grant_alu = alu_valid;
        grant_lsu = lsu_valid;
      end
    end
  end

  assign alu_ready = grant_alu;
  assign lsu_ready = grant_lsu;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    rf_we_d   = 1'b0;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;

    unique case (state_q)
      ST_INIT: begin
        rf_we_d   = 1'b1;
        rf_rd_d   = cnt_q;
        rf_data_d = '0;
        cnt_d     = cnt_q + 5'd1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Writes to x0 are consumed but suppressed at the port.
        if (grant_alu) begin
          rf_we_d   = (alu_rd != 5'd0);
          rf_rd_d   = alu_rd;
          rf_data_d = alu_data;
          last_d    = SRC_ALU;
        end else if (grant_lsu) begin
          rf_we_d   = (lsu_rd != 5'd0);
          rf_rd_d   = lsu_rd;
          rf_data_d = lsu_data;
          last_d    = SRC_LSU;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_INIT;
      cnt_q     <= 5'd0;
      last_q    <= SRC_LSU;
      rf_we_q   <= 1'b0;
      rf_rd_q   <= 5'd0;
      rf_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      rf_we_q   <= rf_we_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_rd     = rf_rd_q;
  assign rf_data   = rf_data_q;
  assign init_busy = (state_q == ST_INIT);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: randomized sources checked every cycle against a
// spec-level model, plus directed scenarios pinned with literal expectations.
module tb_regfile_wb_arbiter;
  localparam int WIDTH = 32;
  localparam int NREG  = 32;
  localparam int IW    = WIDTH + 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             alu_valid, lsu_valid;
  logic [4:0]       alu_rd, lsu_rd;
  logic [WIDTH-1:0] alu_data, lsu_data;
  logic             alu_ready, lsu_ready;
  logic             rf_we;
  logic [4:0]       rf_rd;
  logic [WIDTH-1:0] rf_data;
  logic             init_busy;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.WIDTH(WIDTH), .NREG(NREG)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data), .init_busy(init_busy)
  );

  int checks = 0;
  int failures = 0;

  // Model: edges since reset release, who won last, and the held port contents.
  int               m_edges;
  bit               m_last_lsu;
  logic [4:0]       m_rd;
  logic [WIDTH-1:0] m_data;

  logic [IW-1:0] alu_src_q[$];
  logic [IW-1:0] lsu_src_q[$];
  logic [IW-1:0] exp_q[$];
  logic [4:0]    wr_log[$];
  int            alu_pct, lsu_pct;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_sources();
    if (!alu_valid && alu_src_q.size() > 0 && $urandom_range(99, 0) < alu_pct) begin
      alu_valid = 1'b1;
      alu_rd    = alu_src_q[0][IW-1:WIDTH];
      alu_data  = alu_src_q[0][WIDTH-1:0];
    end
    if (!lsu_valid && lsu_src_q.size() > 0 && $urandom_range(99, 0) < lsu_pct) begin
      lsu_valid = 1'b1;
      lsu_rd    = lsu_src_q[0][IW-1:WIDTH];
      lsu_data  = lsu_src_q[0][WIDTH-1:0];
    end
  endtask

  // One clock cycle: drive, check readies mid-cycle, cross the edge, check port.
  task automatic step();
    bit            in_init, ga, gl;
    logic [IW-1:0] item;
    logic [IW-1:0] got;
    drive_sources();
    #1;
    in_init = (m_edges < NREG);
    ga = 1'b0;
    gl = 1'b0;
    if (!in_init) begin
      if (alu_valid && lsu_valid) begin
        ga = m_last_lsu;
        gl = !m_last_lsu;
      end else begin
        ga = alu_valid;
        gl = lsu_valid;
      end
    end
    chk("alu_ready", 64'(alu_ready), 64'(ga));
    chk("lsu_ready", 64'(lsu_ready), 64'(gl));
    chk("init_busy", 64'(init_busy), 64'(in_init));
    item = '0;
    if (ga) item = {alu_rd, alu_data};
    if (gl) item = {lsu_rd, lsu_data};
    if (ga || gl) exp_q.push_back(item);
    @(posedge clk);
    #1;
    if (in_init) begin
      chk("fill_we", 64'(rf_we), 64'd1);
      chk("fill_rd", 64'(rf_rd), 64'(m_edges));
      chk("fill_data", 64'(rf_data), 64'd0);
      m_rd   = 5'(m_edges);
      m_data = '0;
      m_edges++;
    end else if (ga || gl) begin
      got = exp_q.pop_front();
      chk("wr_we", 64'(rf_we), 64'(got[IW-1:WIDTH] != 5'd0));
      chk("wr_rd", 64'(rf_rd), 64'(got[IW-1:WIDTH]));
      chk("wr_data", 64'(rf_data), 64'(got[WIDTH-1:0]));
      m_rd       = got[IW-1:WIDTH];
      m_data     = got[WIDTH-1:0];
      m_last_lsu = gl;
      if (ga) begin
        void'(alu_src_q.pop_front());
        alu_valid = 1'b0;
      end else begin
        void'(lsu_src_q.pop_front());
        lsu_valid = 1'b0;
      end
    end else begin
      chk("idle_we", 64'(rf_we), 64'd0);
      chk("hold_rd", 64'(rf_rd), 64'(m_rd));
      chk("hold_data", 64'(rf_data), 64'(m_data));
    end
    if (!in_init && rf_we) wr_log.push_back(rf_rd);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_rd", 64'(rf_rd), 64'd0);
    chk("rst_data", 64'(rf_data), 64'd0);
    chk("rst_busy", 64'(init_busy), 64'd1);
    chk("rst_alu_ready", 64'(alu_ready), 64'd0);
    chk("rst_lsu_ready", 64'(lsu_ready), 64'd0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    m_edges    = 0;
    m_last_lsu = 1'b1;
    m_rd       = '0;
    m_data     = '0;
    exp_q.delete();
  endtask

  task automatic run_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int fill_cnt;
    int hits;
    logic [4:0] ord[8];
    logic [4:0] ord2[5];
    alu_valid = 1'b0; lsu_valid = 1'b0;
    alu_rd = '0; lsu_rd = '0; alu_data = '0; lsu_data = '0;
    alu_pct = 100; lsu_pct = 100;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Plain fill with both sources idle.
    fill_cnt = 0;
    for (int i = 0; i < NREG; i++) begin
      step();
      if (rf_we) fill_cnt++;
    end
    chk("fill_count", 64'(fill_cnt), 64'd32);
    chk("fill_last_rd", 64'(rf_rd), 64'd31);
    step();
    chk("post_fill_we", 64'(rf_we), 64'd0);
    run_steps(2);

    // ALU request raised during INIT is held off until RUN.
    do_reset();
    alu_src_q.push_back({5'd5, 32'hDEADBEEF});
    run_steps(NREG);
    step();
    chk("init_req_we", 64'(rf_we), 64'd1);
    chk("init_req_rd", 64'(rf_rd), 64'd5);
    chk("init_req_data", 64'(rf_data), 64'hDEADBEEF);

    // x0 write accepted but suppressed, then a normal LSU write.
    lsu_src_q.push_back({5'd0, 32'h1234});
    step();
    chk("x0_we", 64'(rf_we), 64'd0);
    lsu_src_q.push_back({5'd7, 32'h55});
    step();
    chk("lsu7_we", 64'(rf_we), 64'd1);
    chk("lsu7_rd", 64'(rf_rd), 64'd7);
    chk("lsu7_data", 64'(rf_data), 64'h55);

    // Continuous contention alternates, ALU first since LSU won last.
    wr_log.delete();
    for (int i = 1; i <= 4; i++) begin
      alu_src_q.push_back({5'(i), 32'(32'h10 + i)});
      lsu_src_q.push_back({5'(8 + i), 32'(32'h90 + i)});
    end
    run_steps(8);
    ord = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11, 5'd4, 5'd12};
    chk("contend_len", 64'(wr_log.size()), 64'd8);
    for (int i = 0; i < 8; i++) chk("contend_order", 64'(wr_log[i]), 64'(ord[i]));

    // LSU streams alone, then ALU joins and wins the next slot.
    wr_log.delete();
    for (int i = 3; i <= 6; i++) lsu_src_q.push_back({5'(i), 32'(32'hA0 + i)});
    run_steps(3);
    alu_src_q.push_back({5'd8, 32'hB8});
    run_steps(2);
    ord2 = '{5'd3, 5'd4, 5'd5, 5'd8, 5'd6};
    chk("stream_len", 64'(wr_log.size()), 64'd5);
    for (int i = 0; i < 5; i++) chk("stream_order", 64'(wr_log[i]), 64'(ord2[i]));

    // Reset pulse in RUN while ALU is valid: fill replays, write lands once.
    alu_src_q.push_back({5'd6, 32'hA5});
    drive_sources();
    #1;
    chk("pre_rst_alu_ready", 64'(alu_ready), 64'd1);
    do_reset();
    wr_log.delete();
    run_steps(NREG + 4);
    hits = 0;
    foreach (wr_log[i]) if (wr_log[i] == 5'd6) hits++;
    chk("rst_replay_once", 64'(hits), 64'd1);

    // Reset in the middle of a fill.
    do_reset();
    run_steps(10);
    do_reset();
    run_steps(NREG);

    // Randomized traffic with a mid-RUN reset.
    alu_pct = 60;
    lsu_pct = 60;
    for (int c = 0; c < 400; c++) begin
      if (alu_src_q.size() < 3 && $urandom_range(99, 0) < 50)
        alu_src_q.push_back({5'($urandom_range(31, 0)), 32'($urandom)});
      if (lsu_src_q.size() < 3 && $urandom_range(99, 0) < 50)
        lsu_src_q.push_back({5'($urandom_range(31, 0)), 32'($urandom)});
      if (c == 200) do_reset();
      step();
    end
    alu_pct = 100;
    lsu_pct = 100;
    for (int c = 0; c < 100 && (alu_src_q.size() + lsu_src_q.size()) > 0; c++) step();
    chk("drain", 64'(alu_src_q.size() + lsu_src_q.size()), 64'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port controller for the processor's 32-entry register file. After reset it sequences a zero-fill of every register, then shares the single register-file write port between two writeback sources, the ALU and the load/store unit, using round-robin arbitration with valid/ready handshakes. Its registered write outputs drive the register file's write port directly and are the only writer of that port.

## Interface
- WIDTH, 32, data width of a register
- NREG, 32, number of registers to zero-fill; legal range 2..32

- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU has a writeback pending
- alu_rd  in  5  ALU destination register
- alu_data  in  WIDTH  ALU result
- alu_ready  out  1  ALU writeback accepted this cycle
- lsu_valid  in  1  LSU has a writeback pending
- lsu_rd  in  5  LSU destination register
- lsu_data  in  WIDTH  load data
- lsu_ready  out  1  LSU writeback accepted this cycle
- rf_we  out  1  register-file write enable (registered)
- rf_rd  out  5  register-file write address (registered)
- rf_data  out  WIDTH  register-file write data (registered)
- init_busy  out  1  zero-fill in progress; high from reset until fill completes

## Operation
- States: INIT and RUN. Reset forces INIT, clears the fill counter to 0, and sets last_grant to LSU.
- INIT:
  - Each edge registers a write: rf_we=1, rf_rd=counter, rf_data=0. Counter then increments.
  - The edge that registers rf_rd=NREG-1 also moves the state to RUN.
  - alu_ready and lsu_ready are 0 throughout INIT. init_busy = (state==INIT).
- RUN, grant is combinational:
  - Only one source valid: grant that source.
  - Both valid: grant the source other than last_grant.
  - Neither valid: no grant.
- The ready outputs are high only for the granted source. A source's ready may depend on the other source's valid. A handshake is valid && ready in the same cycle.
- On a handshake edge:
  - rf_rd and rf_data take the granted source's rd and data.
  - rf_we = (rd != 0). A write to x0 is accepted and consumed but not written.
  - last_grant takes the granted source.
- With no handshake, rf_we=0. rf_rd and rf_data hold their previous values.
- Sources must hold valid, rd and data stable until their handshake. The arbiter never drops or duplicates an accepted write.

## Timing
- Reset values (asynchronous, immediate):
  - rf_we=0, rf_rd=0, rf_data=0
  - init_busy=1, alu_ready=0, lsu_ready=0
  - state INIT, counter 0, last_grant=LSU
- Fill sequence after rst deasserts:
  - Edge k (k=1..NREG) presents rf_we=1 with rf_rd=k-1.
  - init_busy falls after edge NREG.
  - Ready can first assert in the cycle after edge NREG.
  - The first accepted write appears after edge NREG+1, giving back-to-back writes with no gap.
- Latency: a handshake sampled at edge t shows rf_we/rf_rd/rf_data during the cycle after edge t, for exactly one cycle.
- Throughput: one write per cycle. Under continuous contention the grants alternate strictly, ALU first after reset.
- A valid that rises while its source is not granted waits. With both sources continuously valid, no source waits more than one cycle.
- Reset asserted mid-INIT or mid-RUN:
  - Outputs clear immediately and the fill restarts from register 0.
  - A write registered but not yet consumed by the register file is lost.
  - A pending valid is not accepted until the next RUN.
- alu_rd/lsu_rd values of NREG or above in RUN are passed through unchanged. Range checking is the decoder's job.

## Test plan
- Reset, release, NREG=32, both valids low -> rf_we=1 for 32 consecutive cycles with rf_rd 0..31 and rf_data=0. init_busy falls after edge 32. rf_we=0 afterwards.
- ALU valid, rd=5, data=0xDEADBEEF asserted during INIT -> alu_ready stays 0 until RUN. It is accepted in the first RUN cycle, and the next cycle shows rf_we=1, rf_rd=5, rf_data=0xDEADBEEF.
- Both sources continuously valid for 4 handshakes (ALU rd=1..4 data=0x10.., LSU rd=9..12 data=0x90..) -> writes in the order ALU1, LSU9, ALU2, LSU10, ..., one per cycle with no gaps.
- LSU valid alone with rd=0, data=0x1234 -> lsu_ready=1 and the handshake completes. The next cycle shows rf_we=0. Then LSU rd=7, data=0x55 -> rf_we=1, rf_rd=7, rf_data=0x55.
- LSU streams rd=3,4,5 back-to-back while ALU is idle -> three consecutive write cycles. ALU then asserts while LSU is still valid -> ALU is granted next because last_grant=LSU.
- rst pulsed for 1 cycle in RUN while ALU valid -> rf_we and both readies drop at once. A full 32-cycle fill replays, then the held ALU write is accepted exactly once.
